hazard_controller: RTL and testbench

Pipeline sequencing controller for the 5-stage RISC-V core. It drives the per-stage register enables and flushes from three causes: load-use hazards in ID, taken branches/jumps resolved in EX, and multi-cycle data-memory accesses in MEM. A timeout watchdog traps a hung memory access. It sits beside the forwarding unit: forwarding covers ALU-to-ALU dependences, and this block covers the hazards forwarding cannot resolve.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/hazard_perf_cnt.sv | 41 ++++
 rtl/hazard_controller.sv | 145 ++++++++++++++
 tb/tb_hazard_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared types and constants for the 5-stage pipeline control.
//  Revision    : 1.0  initial release
// ============================================================================
package pipeline_pkg;

    localparam int unsigned c_reg_idx_w  = 5;
    localparam int unsigned c_perf_cnt_w = 32;
    localparam logic [c_reg_idx_w-1:0] c_x0_idx = '0;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERROR    = 2'b10
    } hz_state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_perf_cnt
//  Description : Wrapping stall / load-use / flush event counters.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_perf_cnt
    import pipeline_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_evt,
    input  logic                    load_use_evt,
    input  logic                    flush_evt,
    output logic [c_perf_cnt_w-1:0] perf_stall_cycles,
    output logic [c_perf_cnt_w-1:0] perf_load_use,
    output logic [c_perf_cnt_w-1:0] perf_flushes
);

    logic [c_perf_cnt_w-1:0] r_stall_cycles;
    logic [c_perf_cnt_w-1:0] r_load_use;
    logic [c_perf_cnt_w-1:0] r_flushes;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_load_use     <= '0;
            r_flushes      <= '0;
        end else begin
            if (stall_evt)    r_stall_cycles <= r_stall_cycles + 1'b1;
            if (load_use_evt) r_load_use     <= r_load_use + 1'b1;
            if (flush_evt)    r_flushes      <= r_flushes + 1'b1;
        end
    end

    assign perf_stall_cycles = r_stall_cycles;
    assign perf_load_use     = r_load_use;
    assign perf_flushes      = r_flushes;

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_controller
//  Description : Pipeline enable/flush sequencing for load-use, branch and
//                memory-wait hazards with a memory timeout trap.
//                Optional counters enabled by macro HAZARD_PERF_CNT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_controller
    import pipeline_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_read_EX,
    input  logic [c_reg_idx_w-1:0]  rd_EX,
    input  logic [c_reg_idx_w-1:0]  rs1_ID,
    input  logic [c_reg_idx_w-1:0]  rs2_ID,
    input  logic                    rs1_used_ID,
    input  logic                    rs2_used_ID,
    input  logic                    branch_taken_EX,
    input  logic                    mem_req_MEM,
    input  logic                    mem_ready,
    output logic                    pc_en,
    output logic                    if_id_en,
    output logic                    id_ex_en,
    output logic                    ex_mem_en,
    output logic                    mem_wb_en,
    output logic                    if_id_flush,
    output logic                    id_ex_flush,
    output logic                    mem_wb_flush,
    output logic                    mem_err,
    output logic [c_perf_cnt_w-1:0] perf_stall_cycles,
    output logic [c_perf_cnt_w-1:0] perf_load_use,
    output logic [c_perf_cnt_w-1:0] perf_flushes
);

    localparam logic [15:0] c_wait_last = 16'(MEM_TIMEOUT - 1);

    hz_state_e   r_state;
    hz_state_e   w_state_nxt;
    logic [15:0] r_wait_cnt;
    logic        r_mem_err;
    logic        w_active;
    logic        w_mem_stall;
    logic        w_load_use;

    assign w_active    = (r_state != ERROR);
    assign w_mem_stall = w_active && mem_req_MEM && !mem_ready;
    assign w_load_use  = mem_read_EX && (rd_EX != c_x0_idx) &&
                         ((rs1_used_ID && (rs1_ID == rd_EX)) ||
                          (rs2_used_ID && (rs2_ID == rd_EX)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= (r_state == MEM_WAIT) ? r_wait_cnt + 16'd1 : 16'd0;
            if (w_state_nxt == ERROR) r_mem_err <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:      if (w_mem_stall) w_state_nxt = MEM_WAIT;
            MEM_WAIT: begin
                if (mem_ready)                     w_state_nxt = RUN;
                else if (r_wait_cnt == c_wait_last) w_state_nxt = ERROR;
            end
            ERROR:    w_state_nxt = ERROR;
            default:  w_state_nxt = RUN;
        endcase
    end

    // A branch that coincides with a memory stall is held off until mem_ready,
    // since the frozen EX stage keeps presenting it.
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        if (!rst && w_active) begin
            if (w_mem_stall) begin
                mem_wb_flush = 1'b1;
            end else if (branch_taken_EX) begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (w_load_use) begin
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
            end
        end
    end

    assign mem_err = r_mem_err;

`ifdef HAZARD_PERF_CNT_EN
    logic w_flush_evt;
    logic w_lu_evt;
    logic w_stall_evt;

    assign w_flush_evt = w_active && !w_mem_stall && branch_taken_EX;
    assign w_lu_evt    = w_active && !w_mem_stall && !branch_taken_EX && w_load_use;
    assign w_stall_evt = w_mem_stall || w_lu_evt;

    hazard_perf_cnt u_perf_cnt (
        .clk               (clk),
        .rst               (rst),
        .stall_evt         (w_stall_evt),
        .load_use_evt      (w_lu_evt),
        .flush_evt         (w_flush_evt),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_load_use     (perf_load_use),
        .perf_flushes      (perf_flushes)
    );
`else
    assign perf_stall_cycles = '0;
    assign perf_load_use     = '0;
    assign perf_flushes      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_controller
//  Description : Self-checking bench for hazard_controller against a
//                cause-priority reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_controller;
    import pipeline_pkg::*;

    localparam int unsigned TO = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Control vector order: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, mem_wb_fl}
    localparam logic [7:0] CTL_ZERO  = 8'b00000_000;
    localparam logic [7:0] CTL_RUN   = 8'b11111_000;
    localparam logic [7:0] CTL_MEM   = 8'b00000_001;
    localparam logic [7:0] CTL_BR    = 8'b11111_110;
    localparam logic [7:0] CTL_LU    = 8'b00111_010;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_read_EX;
    logic [4:0] rd_EX, rs1_ID, rs2_ID;
    logic       rs1_used_ID, rs2_used_ID;
    logic       branch_taken_EX, mem_req_MEM, mem_ready;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
    logic [31:0] perf_stall_cycles, perf_load_use, perf_flushes;
    logic [7:0]  act_ctl;

    hazard_controller #(.MEM_TIMEOUT(TO)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_read_EX       (mem_read_EX),
        .rd_EX             (rd_EX),
        .rs1_ID            (rs1_ID),
        .rs2_ID            (rs2_ID),
        .rs1_used_ID       (rs1_used_ID),
        .rs2_used_ID       (rs2_used_ID),
        .branch_taken_EX   (branch_taken_EX),
        .mem_req_MEM       (mem_req_MEM),
        .mem_ready         (mem_ready),
        .pc_en             (pc_en),
        .if_id_en          (if_id_en),
        .id_ex_en          (id_ex_en),
        .ex_mem_en         (ex_mem_en),
        .mem_wb_en         (mem_wb_en),
        .if_id_flush       (if_id_flush),
        .id_ex_flush       (id_ex_flush),
        .mem_wb_flush      (mem_wb_flush),
        .mem_err           (mem_err),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_load_use     (perf_load_use),
        .perf_flushes      (perf_flushes)
    );

    assign act_ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                      if_id_flush, id_ex_flush, mem_wb_flush};

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: trap after TO+1 consecutive stalled cycles
    bit          m_err;
    int          m_consec;
    logic [31:0] m_stall, m_lu, m_fl;
    bit          ev_stall, ev_lu, ev_fl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_ctl(output bit se, output bit le, output bit fe);
        bit ms, lu;
        se = 0; le = 0; fe = 0;
        if (rst || m_err) return CTL_ZERO;
        ms = mem_req_MEM && !mem_ready;
        lu = mem_read_EX && (rd_EX != 0) &&
             ((rs1_used_ID && rs1_ID == rd_EX) || (rs2_used_ID && rs2_ID == rd_EX));
        if (ms) begin se = 1; return CTL_MEM; end
        if (branch_taken_EX) begin fe = 1; return CTL_BR; end
        if (lu) begin se = 1; le = 1; return CTL_LU; end
        return CTL_RUN;
    endfunction

    task automatic model_reset();
        m_err = 0; m_consec = 0; m_stall = 0; m_lu = 0; m_fl = 0;
    endtask

    // Mid-cycle compare of all outputs against the model
    task automatic mid();
        logic [7:0] e;
        #4;
        if (rst) model_reset();
        e = model_ctl(ev_stall, ev_lu, ev_fl);
        chk("ctl", {24'd0, act_ctl}, {24'd0, e});
        chk("mem_err", {31'd0, mem_err}, {31'd0, m_err});
        chk("perf_stall", perf_stall_cycles, PERF ? m_stall : 32'd0);
        chk("perf_lu", perf_load_use, PERF ? m_lu : 32'd0);
        chk("perf_fl", perf_flushes, PERF ? m_fl : 32'd0);
    endtask

    task automatic fin();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (!m_err) begin
            if (mem_req_MEM && !mem_ready) begin
                m_consec++;
                if (m_consec == int'(TO) + 1) m_err = 1;
            end else begin
                m_consec = 0;
            end
            if (ev_stall) m_stall++;
            if (ev_lu)    m_lu++;
            if (ev_fl)    m_fl++;
        end
        #1;
    endtask

    task automatic set_idle();
        mem_read_EX = 0; rd_EX = 0; rs1_ID = 0; rs2_ID = 0;
        rs1_used_ID = 0; rs2_used_ID = 0; branch_taken_EX = 0;
        mem_req_MEM = 0; mem_ready = 0;
    endtask

    initial begin
        int pend;
        int n;
        model_reset();
        rst = 1;
        set_idle();
        @(posedge clk);
        #1;

        // Reset state
        mid(); chk("lit_reset_ctl", {24'd0, act_ctl}, 32'h00); fin();
        rst = 0;
        mid(); chk("lit_idle_ctl", {24'd0, act_ctl}, 32'hF8); fin();

        // Load x5 in EX, add x6,x5,x1 in ID
        mem_read_EX = 1; rd_EX = 5; rs1_ID = 5; rs1_used_ID = 1; rs2_ID = 1; rs2_used_ID = 1;
        mid(); chk("lit_lu_ctl", {24'd0, act_ctl}, 32'h3A); fin();
        set_idle();
        mid(); chk("lit_lu_cnt", perf_load_use, PERF ? 32'd1 : 32'd0); fin();

        // Load to x0 never stalls
        mem_read_EX = 1; rd_EX = 0; rs1_ID = 0; rs1_used_ID = 1;
        mid(); chk("lit_x0_ctl", {24'd0, act_ctl}, 32'hF8); fin();

        // Branch masks a coincident load-use
        mem_read_EX = 1; rd_EX = 5; rs1_ID = 5; rs1_used_ID = 1; branch_taken_EX = 1;
        mid(); chk("lit_br_ctl", {24'd0, act_ctl}, 32'hFE); fin();
        set_idle();
        mid();
        chk("lit_br_fl", perf_flushes, PERF ? 32'd1 : 32'd0);
        chk("lit_br_lu", perf_load_use, PERF ? 32'd1 : 32'd0);
        fin();

        // Memory access ready after 3 cycles, with a deferred branch
        mem_req_MEM = 1; branch_taken_EX = 1;
        for (int i = 0; i < 3; i++) begin
            mid(); chk("lit_mem_ctl", {24'd0, act_ctl}, 32'h01); fin();
        end
        mem_ready = 1;
        mid(); chk("lit_mem_done", {24'd0, act_ctl}, 32'hFE); fin();
        set_idle();
        mid(); chk("lit_mem_stall_cnt", perf_stall_cycles, PERF ? 32'd4 : 32'd0); fin();

        // Timeout trap
        mem_req_MEM = 1;
        for (int i = 0; i < int'(TO) + 1; i++) begin
            mid(); chk("lit_to_wait", {31'd0, mem_err}, 32'd0); fin();
        end
        mid();
        chk("lit_to_err", {31'd0, mem_err}, 32'd1);
        chk("lit_to_ctl", {24'd0, act_ctl}, 32'h00);
        fin();
        mem_ready = 1;
        mid(); chk("lit_err_absorb", {24'd0, act_ctl}, 32'h00); fin();
        set_idle();
        rst = 1;
        mid(); chk("lit_rst_err", {31'd0, mem_err}, 32'd0); fin();
        rst = 0;
        mid(); chk("lit_rst_run", {24'd0, act_ctl}, 32'hF8); fin();

        // Reset mid-wait, released with mem_ready high
        mem_req_MEM = 1;
        mid(); fin();
        mid(); fin();
        rst = 1;
        mid(); chk("lit_rst_wait_ctl", {24'd0, act_ctl}, 32'h00); fin();
        rst = 0; mem_ready = 1;
        mid();
        chk("lit_rel_ctl", {24'd0, act_ctl}, 32'hF8);
        chk("lit_rel_cnt", perf_stall_cycles, 32'd0);
        fin();
        set_idle();

        // Randomized phase
        pend = -1;
        for (int c = 0; c < 3000; c++) begin
            if (rst) begin
                rst = 0;
            end else if ($urandom_range(0, 79) == 0 || (m_err && $urandom_range(0, 3) == 0)) begin
                rst  = 1;
                pend = -1;
            end
            mem_read_EX     = 1'($urandom_range(0, 1));
            rd_EX           = 5'($urandom_range(0, 3));
            rs1_ID          = 5'($urandom_range(0, 3));
            rs2_ID          = 5'($urandom_range(0, 3));
            rs1_used_ID     = 1'($urandom_range(0, 1));
            rs2_used_ID     = 1'($urandom_range(0, 1));
            branch_taken_EX = ($urandom_range(0, 4) == 0);
            if (pend > 0) begin
                mem_req_MEM = 1; mem_ready = 0; pend--;
            end else if (pend == 0) begin
                mem_req_MEM = 1; mem_ready = 1; pend = -1;
            end else if (!rst && $urandom_range(0, 5) == 0) begin
                n = int'($urandom_range(0, 6));
                mem_req_MEM = 1;
                mem_ready   = (n == 0);
                pend        = (n == 0) ? -1 : n - 1;
            end else begin
                mem_req_MEM = 0;
                mem_ready   = 1'($urandom_range(0, 1));
            end
            mid();
            fin();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
